seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//   Parametrised serial pattern detector: generalised successor of the fixed 4-bit "0101" detector.
//   Samples one bit per qualified clock and pulses 'match' when the last PAT_W sampled bits equal
//   the active pattern (MSB = oldest bit).
//   Adds: runtime-loadable pattern, overlap/non-overlap mode, input qualifier, saturating match counter.
//   Sits between a serial bit source (deserialiser/UART RX path) and control/status logic.
// PARAMETERS
//   PAT_W     4        pattern length in bits, legal 2..16
//   PAT_INIT  4'b0101  pattern active after reset (PAT_W bits wide)
//   OVERLAP   1        1 = overlapping matches allowed; 0 = history restarts after each match
//   CNT_W     8        width of saturating match counter, legal 1..32
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      asynchronous reset, ACTIVE-LOW (rst==0 resets immediately)
//   in_valid   in   1      qualifies 'in'; bit sampled only when 1
//   in         in   1      serial data bit
//   pat_load   in   1      load pat_in as active pattern (one-cycle strobe)
//   pat_in     in   PAT_W  new pattern, MSB = first bit of sequence
//   cnt_clr    in   1      synchronous clear of match_cnt
//   match      out  1      registered one-cycle pulse per detected occurrence
//   match_cnt  out  CNT_W  number of matches since reset/clear, saturating
//   pattern    out  PAT_W  currently active pattern
// BEHAVIOUR
//   Reset (rst==0, async): match=0, match_cnt=0, pattern=PAT_INIT, history=0, fill=0.
//   Internal state: hist[PAT_W-1:0] shift register; fill counter 0..PAT_W (bits held since restart).
//   Sample edge (in_valid=1, pat_load=0): hist <= {hist[PAT_W-2:0], in}; fill <= min(fill+1, PAT_W).
//   Hit on that edge: fill_next==PAT_W and hist_next==pattern.
//     -> match=1 for exactly the next cycle (registered; latency 1 clk after last bit's sampling edge)
//     -> match_cnt += 1 on the same edge, holds at 2^CNT_W-1 (no wrap)
//     -> OVERLAP=1: hist/fill kept, so "0101010" gives matches at bits 4 and 6
//     -> OVERLAP=0: fill <= 0 (hist content ignored), next match needs PAT_W fresh bits
//   No hit or in_valid=0: match=0; hist/fill/match_cnt hold. in_valid gaps do not break a sequence.
//   pat_load=1: pattern <= pat_in; fill <= 0; bit on 'in' that cycle discarded; match=0 next cycle.
//   cnt_clr=1: match_cnt <= 0; if a hit occurs on the same edge, match_cnt <= 1 (hit counted after clear).
//   pat_load and cnt_clr same cycle: both take effect.
//   Fewer than PAT_W bits since reset/load/restart never match, even if hist (zeros) equals pattern
//     (e.g. pattern 0000 needs 4 real sampled zeros).
//   Reset mid-sequence: partial history lost; the match pulse, if in flight, is cleared immediately.
//   No combinational path from inputs to outputs.
// TESTING
//   T1 default, OVERLAP=1: bits 0,1,0,1,0,1 (in_valid=1) -> match pulses after bits 4 and 6; match_cnt=2.
//   T2 OVERLAP=0, same stream, then 0,1 -> match after bits 4 and 8 only; match_cnt=2.
//   T3 bits 0,1 then in_valid=0 for 3 clks, then 0,1 -> single match 1 clk after last bit; cnt=1.
//   T4 pat_load pat_in=4'b1100 mid-stream, then 1,1,0,0,1,1,0,0 -> matches after bits 4 and 8;
//      old 0101 stream gives none; pattern reads 4'b1100.
//   T5 CNT_W=2: 5 matches -> match_cnt 1,2,3,3,3; cnt_clr together with a hit -> match_cnt=1.
//   T6 assert rst low asynchronously after bits 0,1,0 (between edges) -> outputs 0 immediately;
//      after release, single bit 1 -> no match; pattern=PAT_INIT.

Source files
------------

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//   Parametrised serial pattern detector. Shifts in one bit per qualified clock
//   and raises a registered one-cycle 'match' pulse when the last PAT_W sampled
//   bits equal the active pattern. The oldest bit is the pattern MSB.
//   The pattern can be reloaded at runtime. Matches may overlap or restart the
//   history, depending on OVERLAP. A saturating counter tallies the matches.
//
// Parameters
//   PAT_W     pattern length in bits (2..16)
//   PAT_INIT  pattern active after reset
//   OVERLAP   1: overlapping matches allowed, 0: history restarts after a match
//   CNT_W     width of the saturating match counter (1..32)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   in_valid   in   1      qualifies 'in'
//   in         in   1      serial data bit
//   pat_load   in   1      strobe: pat_in becomes the active pattern
//   pat_in     in   PAT_W  new pattern, MSB = first bit of the sequence
//   cnt_clr    in   1      synchronous clear of match_cnt
//   match      out  1      registered one-cycle pulse per detected occurrence
//   match_cnt  out  CNT_W  saturating count of matches since reset/clear
//   pattern    out  PAT_W  currently active pattern
// -----------------------------------------------------------------------------
module seq_detect_param #(
  parameter int                PAT_W    = 4,
  parameter logic [PAT_W-1:0]  PAT_INIT = 4'b0101,
  parameter bit                OVERLAP  = 1'b1,
  parameter int                CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pattern
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // Only the newest PAT_W-1 bits need to be stored: the oldest of the PAT_W
  // bits compared on a hit is shifted out on that same edge, so it is never
  // needed again.
  logic [PAT_W-2:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              match_q, match_d;

  logic              sample;
  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  // Hit detection works on the history as it will be after this edge.
  // A pattern load wins over a sample, so the bit on 'in' is discarded.
  assign sample   = in_valid && !pat_load;
  assign hist_nxt = {hist_q, in};
  assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  assign hit      = sample && (fill_inc == FILL_FULL) && (hist_nxt == pat_q);

  // NOTE: every signal gets a default value at the top of the block, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    match_d = hit;

    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (sample) begin
      hist_d = hist_nxt[PAT_W-2:0];
      // In non-overlap mode a hit empties the history. The next match then
      // needs PAT_W fresh bits. The old hist contents are masked by fill.
      fill_d = (hit && !OVERLAP) ? '0 : fill_inc;
    end

    // A clear together with a hit still counts that hit.
    if (cnt_clr) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_INIT;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign pattern   = pat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//   Three detector instances are driven from one stimulus bus. A selector
//   gates in_valid, pat_load and cnt_clr, so only one instance sees traffic
//   at a time:
//     u0: defaults (PAT_W=4, 0101, OVERLAP=1, CNT_W=8)
//     u1: OVERLAP=0
//     u2: CNT_W=2
//   The stimulus pushes the expected pulse (instance, cycle, counter value)
//   into a queue. A negedge monitor pops one entry for every match pulse it
//   sees. Any pulse with no matching entry is an error, and so is any entry
//   left over at the end.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, din, pat_load, cnt_clr;
  logic [3:0] pat_in;
  int         sel;

  logic [2:0] iv_g, ld_g, clr_g;
  logic [2:0] match;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [3:0] pat0, pat1, pat2;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int inst;
    int cyc;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  assign iv_g  = in_valid ? (3'b001 << sel) : 3'b000;
  assign ld_g  = pat_load ? (3'b001 << sel) : 3'b000;
  assign clr_g = cnt_clr  ? (3'b001 << sel) : 3'b000;

  seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b0101), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv_g[0]), .in(din), .pat_load(ld_g[0]),
    .pat_in(pat_in), .cnt_clr(clr_g[0]), .match(match[0]), .match_cnt(cnt0),
    .pattern(pat0));

  seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b0101), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv_g[1]), .in(din), .pat_load(ld_g[1]),
    .pat_in(pat_in), .cnt_clr(clr_g[1]), .match(match[1]), .match_cnt(cnt1),
    .pattern(pat1));

  seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b0101), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv_g[2]), .in(din), .pat_load(ld_g[2]),
    .pat_in(pat_in), .cnt_clr(clr_g[2]), .match(match[2]), .match_cnt(cnt2),
    .pattern(pat2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int cnt_of(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (match[i] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_match: inst %0d at cyc %0d, cnt %0d, none expected",
                   i, cyc, cnt_of(i));
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.inst != i || mon_e.cyc != cyc || mon_e.cnt != cnt_of(i)) begin
            errors++;
            $display("FAIL match_pulse: got inst %0d cyc %0d cnt %0d, expected inst %0d cyc %0d cnt %0d",
                     i, cyc, cnt_of(i), mon_e.inst, mon_e.cyc, mon_e.cnt);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one cycle of stimulus to instance 'inst'. If a hit is expected,
  // the pulse is due one cycle later with counter value 'ec'. The caller sets
  // pat_load, pat_in and cnt_clr beforehand, and they are cleared afterwards.
  task automatic send(input int inst, input logic v, input logic b,
                      input bit em, input int ec);
    sel      = inst;
    in_valid = v;
    din      = b;
    if (em) exp_q.push_back('{inst, cyc + 1, ec});
    step();
    in_valid = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    din      = 1'b0;
    pat_load = 1'b0;
    pat_in   = 4'b0000;
    cnt_clr  = 1'b0;
    sel      = 0;
    repeat (2) step();
    rst = 1'b1;

    // Reset state
    check("reset_match", int'(match), 0);
    check("reset_cnt0", int'(cnt0), 0);
    check("reset_pattern0", int'(pat0), 4'b0101);
    check("reset_cnt2", int'(cnt2), 0);

    // T1: overlapping stream 0101010 gives hits on bits 4 and 6
    for (int i = 1; i <= 6; i++)
      send(0, 1'b1, logic'(i % 2 == 0), (i == 4 || i == 6), (i == 4) ? 1 : 2);
    check("t1_cnt", int'(cnt0), 2);

    // T2: non-overlap, 8 bits of 01 repeated gives hits on bits 4 and 8 only
    for (int i = 1; i <= 8; i++)
      send(1, 1'b1, logic'(i % 2 == 0), (i == 4 || i == 8), (i == 4) ? 1 : 2);
    check("t2_cnt", int'(cnt1), 2);

    // Reload the same pattern and clear together: both take effect
    pat_load = 1'b1; pat_in = 4'b0101; cnt_clr = 1'b1;
    send(0, 1'b0, 1'b0, 1'b0, 0);
    check("load_clr_cnt", int'(cnt0), 0);

    // T3: in_valid gaps do not break a sequence; toggling 'in' is ignored
    send(0, 1'b1, 1'b0, 1'b0, 0);
    send(0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) send(0, 1'b0, logic'(i % 2), 1'b0, 0);
    send(0, 1'b1, 1'b0, 1'b0, 0);
    send(0, 1'b1, 1'b1, 1'b1, 1);
    check("t3_cnt", int'(cnt0), 1);

    // T4: history 1010 after one more bit, then load 1100 with in_valid=1 (bit discarded)
    send(0, 1'b1, 1'b0, 1'b0, 0);
    check("t4_pattern_before", int'(pat0), 4'b0101);
    pat_load = 1'b1; pat_in = 4'b1100;
    send(0, 1'b1, 1'b1, 1'b0, 0);
    check("t4_match_after_load", int'(match[0]), 0);
    for (int i = 1; i <= 8; i++)
      send(0, 1'b1, logic'(((i - 1) % 4) < 2), (i == 4 || i == 8), (i == 4) ? 2 : 3);
    check("t4_pattern", int'(pat0), 4'b1100);
    check("t4_cnt", int'(cnt0), 3);

    // Clear alone
    cnt_clr = 1'b1;
    send(0, 1'b0, 1'b0, 1'b0, 0);
    check("clr_cnt", int'(cnt0), 0);

    // Pattern 0000 needs four real sampled zeros
    pat_load = 1'b1; pat_in = 4'b0000;
    send(0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 4; i++) send(0, 1'b1, 1'b0, (i == 4), 1);
    check("zeros_cnt", int'(cnt0), 1);

    // T5: CNT_W=2 saturates at 3, then a clear on a hit edge counts that hit
    for (int i = 1; i <= 12; i++)
      send(2, 1'b1, logic'(i % 2 == 0), (i >= 4 && i % 2 == 0),
           (i / 2 - 1 > 3) ? 3 : i / 2 - 1);
    check("t5_sat_cnt", int'(cnt2), 3);
    send(2, 1'b1, 1'b0, 1'b0, 0);
    cnt_clr = 1'b1;
    send(2, 1'b1, 1'b1, 1'b1, 1);
    check("t5_clr_hit_cnt", int'(cnt2), 1);

    // Reset during a match pulse clears it at once and restores PAT_INIT.
    // Pattern 0000 and full history of zeros, so one more zero hits.
    send(0, 1'b1, 1'b0, 1'b0, 0);
    check("inflight_match_high", int'(match[0]), 1);
    #1 rst = 1'b0;
    #1;
    check("inflight_match_cleared", int'(match[0]), 0);
    check("inflight_cnt_cleared", int'(cnt0), 0);
    check("inflight_pattern_init", int'(pat0), 4'b0101);
    step();
    rst = 1'b1;

    // T6: async reset between edges after bits 0,1,0
    send(0, 1'b1, 1'b0, 1'b0, 0);
    send(0, 1'b1, 1'b1, 1'b0, 0);
    send(0, 1'b1, 1'b0, 1'b0, 0);
    #2 rst = 1'b0;
    #1;
    check("t6_match", int'(match[0]), 0);
    check("t6_cnt", int'(cnt0), 0);
    check("t6_pattern", int'(pat0), 4'b0101);
    step();
    rst = 1'b1;
    send(0, 1'b1, 1'b1, 1'b0, 0);
    check("t6_no_match_cnt", int'(cnt0), 0);

    // Full sequence after reset still detects
    for (int i = 1; i <= 4; i++) send(0, 1'b1, logic'(i % 2 == 0), (i == 4), 1);

    repeat (3) step();
    check("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
